// File: rtl/guvm_stub_pkg.sv
// Shared types and constants for the cache stub: access FSM states, the empty-queue
// NOP word and the parameter defaults used by guvm_cache_stub.
package guvm_stub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int DATA_W_DEF    = 32;
    localparam int IQ_DEPTH_DEF  = 16;
    localparam int MEM_WORDS_DEF = 16;

    // Returned on an instruction fetch that finds the queue empty.
    localparam logic [31:0] SPARC_NOP = 32'h0100_0000;

    // Zero wait states skip WAIT and respond on the very next cycle.
    function automatic state_e leave_idle(input logic [3:0] wait_states);
        return (wait_states == 4'd0) ? ST_RESP : ST_WAIT;
    endfunction

endpackage

// File: rtl/guvm_sync_fifo.sv
// Single-clock FIFO used as the instruction queue. Pushes while full and pops
// while empty are dropped; pointers wrap modulo DEPTH (power of two).
module guvm_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/guvm_cache_stub.sv
// Instruction/data cache stub with programmable wait states, an instruction queue and
// a small data memory. Define GUVM_STUB_ERR_INJ_EN to add the err_inj memory-exception port.
module guvm_cache_stub
    import guvm_stub_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int IQ_DEPTH  = IQ_DEPTH_DEF,
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_valid,
    input  logic [DATA_W-1:0]         push_data,
    output logic                      push_ready,
    output logic [$clog2(IQ_DEPTH):0] iq_count,
    input  logic [3:0]                wait_cfg,
    input  logic                      ireq,
    output logic [DATA_W-1:0]         ic_data,
    output logic                      ic_hold,
    output logic                      ic_exc,
`ifdef GUVM_STUB_ERR_INJ_EN
    input  logic                      err_inj,
`endif
    input  logic                      dreq,
    input  logic                      dwrite,
    input  logic [31:0]               daddr,
    input  logic [DATA_W-1:0]         dwdata,
    output logic [DATA_W-1:0]         dc_data,
    output logic                      dc_hold,
    output logic                      dc_mexc
);

    localparam int MIDX = $clog2(MEM_WORDS);

    // ---------------- instruction channel ----------------
    state_e              ist_q, ist_d;
    logic [3:0]          icnt_q, icnt_d;
    logic [DATA_W-1:0]   ic_last_q;
    logic [DATA_W-1:0]   ic_word;
    logic [DATA_W-1:0]   iq_head;
    logic                iq_empty;
    logic                iq_full;
    logic                i_resp;

    guvm_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (IQ_DEPTH)
    ) u_iq (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_valid),
        .push_data_i (push_data),
        .pop_i       (i_resp && !iq_empty),
        .head_o      (iq_head),
        .count_o     (iq_count),
        .full_o      (iq_full),
        .empty_o     (iq_empty)
    );

    assign push_ready = !iq_full;

    always_comb begin
        ist_d  = ist_q;
        icnt_d = icnt_q;
        unique case (ist_q)
            ST_IDLE: begin
                if (ireq) begin
                    ist_d  = leave_idle(wait_cfg);
                    icnt_d = wait_cfg;
                end
            end
            ST_WAIT: begin
                icnt_d = icnt_q - 4'd1;
                if (icnt_q == 4'd1) ist_d = ST_RESP;
            end
            ST_RESP: ist_d = ST_IDLE;
            default: ist_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ist_q     <= ST_IDLE;
            icnt_q    <= '0;
            ic_last_q <= '0;
        end else begin
            ist_q  <= ist_d;
            icnt_q <= icnt_d;
            if (i_resp) ic_last_q <= ic_word;
        end
    end

    // The response is driven combinationally during RESP and latched on exit, so a
    // reset landing in RESP cancels the pop along with the response.
    assign i_resp  = (ist_q == ST_RESP);
    assign ic_word = iq_empty ? DATA_W'(SPARC_NOP) : iq_head;
    assign ic_data = i_resp ? ic_word : ic_last_q;
    assign ic_exc  = i_resp && iq_empty;
    assign ic_hold = (ist_q != ST_WAIT);

    // ---------------- data channel ----------------
    state_e              dst_q, dst_d;
    logic [3:0]          dcnt_q, dcnt_d;
    logic [MIDX-1:0]     d_idx_q;
    logic                d_we_q;
    logic [DATA_W-1:0]   d_wd_q;
    logic [DATA_W-1:0]   dc_last_q;
    logic [DATA_W-1:0]   dc_word;
    logic [DATA_W-1:0]   mem_q [MEM_WORDS];
    logic                d_resp;
    logic                d_capture;
    logic                inj_hit;
    logic                addr_unused;

    assign addr_unused = ^{daddr[31:MIDX+2], daddr[1:0]};

    always_comb begin
        dst_d     = dst_q;
        dcnt_d    = dcnt_q;
        d_capture = 1'b0;
        unique case (dst_q)
            ST_IDLE: begin
                if (dreq) begin
                    dst_d     = leave_idle(wait_cfg);
                    dcnt_d    = wait_cfg;
                    d_capture = 1'b1;
                end
            end
            ST_WAIT: begin
                dcnt_d = dcnt_q - 4'd1;
                if (dcnt_q == 4'd1) dst_d = ST_RESP;
            end
            ST_RESP: dst_d = ST_IDLE;
            default: dst_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dst_q     <= ST_IDLE;
            dcnt_q    <= '0;
            dc_last_q <= '0;
        end else begin
            dst_q  <= dst_d;
            dcnt_q <= dcnt_d;
            if (d_resp) dc_last_q <= dc_word;
        end
    end

    always_ff @(posedge clk) begin
        if (d_capture) begin
            d_idx_q <= daddr[MIDX+1:2];
            d_we_q  <= dwrite;
            d_wd_q  <= dwdata;
        end
    end

    // Writes commit on the RESP edge; reset takes priority and clears the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
        end else if (d_resp && d_we_q && !inj_hit) begin
            mem_q[d_idx_q] <= d_wd_q;
        end
    end

    assign d_resp  = (dst_q == ST_RESP);
    assign dc_word = d_we_q ? d_wd_q : mem_q[d_idx_q];
    assign dc_data = d_resp ? dc_word : dc_last_q;
    assign dc_hold = (dst_q != ST_WAIT);

`ifdef GUVM_STUB_ERR_INJ_EN
    logic inj_q;

    // An armed flag is consumed by the next data response; a new pulse re-arms it.
    always_ff @(posedge clk) begin
        if (rst) inj_q <= 1'b0;
        else     inj_q <= (inj_q && !d_resp) || err_inj;
    end

    assign inj_hit = d_resp && inj_q;
    assign dc_mexc = inj_hit;
`else
    assign inj_hit = 1'b0;
    assign dc_mexc = 1'b0;
`endif

endmodule

// File: tb/tb_guvm_cache_stub.sv
// Directed self-checking bench for guvm_cache_stub; follows GUVM_STUB_ERR_INJ_EN when defined.
module tb_guvm_cache_stub;

    localparam int DATA_W    = 32;
    localparam int IQ_DEPTH  = 16;
    localparam int MEM_WORDS = 16;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      push_valid;
    logic [DATA_W-1:0]         push_data;
    logic                      push_ready;
    logic [$clog2(IQ_DEPTH):0] iq_count;
    logic [3:0]                wait_cfg;
    logic                      ireq;
    logic [DATA_W-1:0]         ic_data;
    logic                      ic_hold;
    logic                      ic_exc;
    logic                      err_inj;
    logic                      dreq;
    logic                      dwrite;
    logic [31:0]               daddr;
    logic [DATA_W-1:0]         dwdata;
    logic [DATA_W-1:0]         dc_data;
    logic                      dc_hold;
    logic                      dc_mexc;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    guvm_cache_stub #(
        .DATA_W    (DATA_W),
        .IQ_DEPTH  (IQ_DEPTH),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .iq_count   (iq_count),
        .wait_cfg   (wait_cfg),
        .ireq       (ireq),
        .ic_data    (ic_data),
        .ic_hold    (ic_hold),
        .ic_exc     (ic_exc),
`ifdef GUVM_STUB_ERR_INJ_EN
        .err_inj    (err_inj),
`endif
        .dreq       (dreq),
        .dwrite     (dwrite),
        .daddr      (daddr),
        .dwdata     (dwdata),
        .dc_data    (dc_data),
        .dc_hold    (dc_hold),
        .dc_mexc    (dc_mexc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic data_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] ws);
        dreq = 1'b1; dwrite = wr; daddr = addr; dwdata = wd; wait_cfg = ws;
        step();
        dreq = 1'b0; dwrite = 1'b0; dwdata = '0;
    endtask

    initial begin
        rst = 1'b1; push_valid = 1'b0; push_data = '0; wait_cfg = '0; ireq = 1'b0;
        err_inj = 1'b0; dreq = 1'b0; dwrite = 1'b0; daddr = '0; dwdata = '0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_iq_count", 32'(iq_count), 32'd0);
        chk("rst_push_ready", 32'(push_ready), 32'd1);
        chk("rst_ic_hold", 32'(ic_hold), 32'd1);
        chk("rst_dc_hold", 32'(dc_hold), 32'd1);
        chk("rst_ic_data", ic_data, 32'd0);
        chk("rst_dc_data", dc_data, 32'd0);
        chk("rst_ic_exc", 32'(ic_exc), 32'd0);
        chk("rst_dc_mexc", 32'(dc_mexc), 32'd0);

        // zero-wait fetch of a queued word
        push_valid = 1'b1; push_data = 32'h8E00_C002;
        step();
        push_valid = 1'b0;
        chk("push1_count", 32'(iq_count), 32'd1);
        ireq = 1'b1;
        step();
        ireq = 1'b0;
        chk("w0_ic_data", ic_data, 32'h8E00_C002);
        chk("w0_ic_hold", 32'(ic_hold), 32'd1);
        chk("w0_ic_exc", 32'(ic_exc), 32'd0);
        step();
        chk("w0_pop_count", 32'(iq_count), 32'd0);
        chk("w0_data_held", ic_data, 32'h8E00_C002);

        // three wait states; wait_cfg changes during WAIT must be ignored
        push_valid = 1'b1; push_data = 32'hA5A5_0001;
        step();
        push_valid = 1'b0; wait_cfg = 4'd3; ireq = 1'b1;
        step();
        ireq = 1'b0; wait_cfg = 4'd0;
        chk("w3_hold_c1", 32'(ic_hold), 32'd0);
        chk("w3_data_held", ic_data, 32'h8E00_C002);
        step();
        chk("w3_hold_c2", 32'(ic_hold), 32'd0);
        step();
        chk("w3_hold_c3", 32'(ic_hold), 32'd0);
        step();
        chk("w3_resp_hold", 32'(ic_hold), 32'd1);
        chk("w3_resp_data", ic_data, 32'hA5A5_0001);
        step();
        chk("w3_count", 32'(iq_count), 32'd0);

        // empty queue returns NOP with exception for exactly one cycle
        ireq = 1'b1;
        step();
        ireq = 1'b0;
        chk("nop_data", ic_data, 32'h0100_0000);
        chk("nop_exc", 32'(ic_exc), 32'd1);
        step();
        chk("nop_exc_clear", 32'(ic_exc), 32'd0);
        chk("nop_count", 32'(iq_count), 32'd0);

        // fill the queue across the pointer wrap, then try a 17th push
        for (int i = 0; i < 16; i++) begin
            push_valid = 1'b1; push_data = 32'h1000_0000 + i;
            step();
        end
        chk("full_ready", 32'(push_ready), 32'd0);
        chk("full_count", 32'(iq_count), 32'd16);
        push_data = 32'hBAD0_BAD0;
        step();
        push_valid = 1'b0;
        chk("overflow_count", 32'(iq_count), 32'd16);
        ireq = 1'b1;
        step();
        ireq = 1'b0;
        chk("full_head", ic_data, 32'h1000_0000);
        step();
        chk("after_pop_count", 32'(iq_count), 32'd15);
        ireq = 1'b1;
        step();
        ireq = 1'b0;
        chk("second_head", ic_data, 32'h1000_0001);
        push_valid = 1'b1; push_data = 32'h2000_0000;
        step();
        push_valid = 1'b0;
        chk("push_pop_count", 32'(iq_count), 32'd15);

        // request held through RESP is not re-sampled there
        ireq = 1'b1;
        step();
        chk("held_req_data", ic_data, 32'h1000_0002);
        step();
        ireq = 1'b0;
        chk("held_req_exc", 32'(ic_exc), 32'd0);
        step();
        chk("held_req_count", 32'(iq_count), 32'd14);
        chk("held_req_data_kept", ic_data, 32'h1000_0002);

`ifdef GUVM_STUB_ERR_INJ_EN
        err_inj = 1'b1;
        step();
        err_inj = 1'b0;
        data_req(1'b1, 32'h0, 32'h1, 4'd0);
        chk("inj_mexc", 32'(dc_mexc), 32'd1);
        step();
        chk("inj_mexc_clear", 32'(dc_mexc), 32'd0);
        data_req(1'b0, 32'h0, 32'h0, 4'd0);
        chk("inj_read_back", dc_data, 32'd0);
        chk("inj_read_mexc", 32'(dc_mexc), 32'd0);
`else
        data_req(1'b1, 32'h0, 32'h1, 4'd0);
        chk("noinj_mexc", 32'(dc_mexc), 32'd0);
        step();
        data_req(1'b0, 32'h0, 32'h0, 4'd0);
        chk("noinj_read_back", dc_data, 32'd1);
        chk("noinj_read_mexc", 32'(dc_mexc), 32'd0);
`endif
        step();

        // aliased address: 0x40 and 0x80 share index 0
        data_req(1'b1, 32'h40, 32'hDEAD_BEEF, 4'd0);
        chk("wr_echo", dc_data, 32'hDEAD_BEEF);
        chk("wr_hold", 32'(dc_hold), 32'd1);
        step();
        data_req(1'b0, 32'h80, 32'h0, 4'd2);
        chk("rd_wait_c1", 32'(dc_hold), 32'd0);
        step();
        chk("rd_wait_c2", 32'(dc_hold), 32'd0);
        step();
        chk("rd_resp_hold", 32'(dc_hold), 32'd1);
        chk("rd_alias_data", dc_data, 32'hDEAD_BEEF);
        step();
        data_req(1'b0, 32'h44, 32'h0, 4'd0);
        chk("rd_other_idx", dc_data, 32'd0);
        step();
        data_req(1'b0, 32'hFFFF_FF40, 32'h0, 4'd0);
        chk("rd_upper_alias", dc_data, 32'hDEAD_BEEF);
        step();

        // reset during the WAIT of a write aborts it
        data_req(1'b1, 32'h44, 32'h1234_5678, 4'd3);
        chk("rstw_wait", 32'(dc_hold), 32'd0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_hold", 32'(dc_hold), 32'd1);
        chk("rstw_data", dc_data, 32'd0);
        step();
        chk("rstw_idle", 32'(dc_hold), 32'd1);
        data_req(1'b0, 32'h44, 32'h0, 4'd0);
        chk("rstw_mem", dc_data, 32'd0);
        chk("rstw_resp_hold", 32'(dc_hold), 32'd1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
